icache_fetch_unit: RTL and testbench
====================================

// Module: icache_fetch_unit
// PURPOSE
//   Direct-mapped instruction cache between the instruction-fetch stage and the memory controller.
//   Serves word-aligned fetches on a hit. On a miss, acts as initiator on the controller's icache port: request, received, task_out, value_load.
//   Refill is one 32-bit word per line; an optional next-line prefetch hides sequential miss latency.
// PARAMETERS
//   INDEX_BITS  4   log2(line count); 16 lines of one 32-bit word each
//   ADDR_WIDTH  32  fetch address width; bits [1:0] ignored; tag = [ADDR_WIDTH-1:INDEX_BITS+2]
// PORTS
//   clk_in            in   1   clock; all logic on rising edge
//   rst_in            in   1   synchronous reset, active-low (0 = reset)
//   rdy_in            in   1   global ready; 0 freezes every register, outputs hold
//   clear_in          in   1   pipeline flush (mispredict); drops the pending fetch response
//   fetch_valid_in    in   1   level; IF holds it high with a stable fetch_pc_in until inst_ready_out
//   fetch_pc_in       in   32  byte address of the instruction
//   inst_ready_out    out  1   one-cycle pulse; inst_out and inst_pc_out are valid
//   inst_out          out  32  instruction word
//   inst_pc_out       out  32  PC the word belongs to
//   icache_in         out  1   refill request to the memory controller, level
//   icache_address_in out  32  refill word address, stable while icache_in=1
//   icache_received   in   1   controller accepted the request, one-cycle pulse
//   icache_task_out   in   1   refill data valid on value_load, one-cycle pulse
//   value_load        in   32  refill word, little-endian assembled
// BEHAVIOUR
//   Reset (rst_in=0 at an edge): all valid bits=0, state=IDLE, icache_in=0, inst_ready_out=0, inst_out=0, inst_pc_out=0, icache_address_in=0.
//   States: IDLE, LOOKUP, REQ, WAIT, RESP.
//   IDLE -> LOOKUP when fetch_valid_in=1; pc is latched.
//   LOOKUP, hit: RESP. Hit latency is 2 cycles from the cycle fetch_valid_in is sampled.
//   LOOKUP, miss: REQ with icache_in=1 and icache_address_in={pc[31:2],2'b00}.
//   REQ: hold icache_in and the address until icache_received=1, then icache_in=0 next cycle -> WAIT.
//     icache_in must never be high in the cycle after received; otherwise the controller serves the request twice.
//   WAIT: on icache_task_out=1, write value_load, set tag and valid -> RESP with inst_out=value_load (forwarded).
//     task_out is accepted only in WAIT; a pulse in any other state is ignored.
//   RESP: inst_ready_out=1 for exactly one cycle -> IDLE.
//     Back-to-back fetches: a new fetch_valid_in is sampled in the IDLE cycle after RESP.
//   clear_in=1, any state: the pending response is cancelled, inst_ready_out is forced 0 that cycle.
//     In REQ/WAIT the in-flight refill still completes and fills the line, but no response is issued.
//     clear_in has priority over a simultaneous task_out response.
//   A refill write to an index overwrites that line unconditionally; there is no replacement choice.
//   The same-index/different-tag fetch following a refill misses (conflict), which is correct behaviour.
//   rdy_in=0: the FSM, array and outputs hold; a pulse on received/task_out while rdy_in=0 is lost.
//     This is legal because the controller is frozen by the same signal.
//   Reset mid-refill: returns to IDLE at once; a stale task_out arriving after reset is ignored (state != WAIT).
// CONFIGURATION
//   ICACHE_PREFETCH_EN defined:
//     After RESP of a demand miss at A, if line A+4 is invalid or tag-mismatched, the FSM enters PF_REQ/PF_WAIT and refills A+4.
//     It does this without an IF response. The address wraps modulo 2^ADDR_WIDTH.
//     A demand fetch during the prefetch waits. If it equals A+4, it is answered on prefetch data (forwarded).
//     Otherwise it is looked up after the prefetch fills.
//     clear_in does not abort a prefetch.
//   ICACHE_PREFETCH_EN undefined: no PF states, no speculative memory traffic; the FSM is exactly as above.
// STRUCTURE
//   icache_pkg holds:
//     - state encoding localparams
//     - INDEX_BITS-derived TAG_BITS
//     - functions get_index(addr), get_tag(addr), and word_align(addr)
//   Sub-module icache_line_store: data, tag and valid arrays.
//     - One synchronous write port; one combinational read port at the latched index, with hit output.
//     - Valid bits clear on reset.
//   The top level keeps the FSM, request/handshake registers and forwarding mux.
// TESTING
//   1. Cold miss: fetch 0x0000_1000; controller model asserts received after 1 cycle and task_out 6 cycles later with 0x0051_3023.
//      -> exactly one icache_in burst; inst_ready_out pulse with inst_out=0x0051_3023, inst_pc_out=0x1000.
//   2. Hit: re-fetch 0x1000 -> inst_ready_out exactly 2 cycles after fetch_valid_in; icache_in stays 0.
//   3. Conflict: with INDEX_BITS=4, fetch 0x1000 then 0x1040 (same index 0) then 0x1000.
//      -> three refills; each response carries the model's word for that address.
//   4. Flush: assert clear_in in WAIT for fetch 0x2000 -> no inst_ready_out.
//      The line is still filled; the next fetch of 0x2000 hits in 2 cycles.
//   5. Freeze/reset: hold rdy_in=0 for 5 cycles in REQ -> icache_in and the address are unchanged and no extra request is made.
//      Then pull rst_in=0 in WAIT -> icache_in=0, and a later fetch of the same PC misses.
//   6. ICACHE_PREFETCH_EN: miss at 0x3000 -> a second request to 0x3004 with no IF response.
//      A fetch of 0x3004 then hits in 2 cycles; without the macro it misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared geometry, FSM encoding and address-slicing helpers for the direct-mapped icache.
// The prefetch states exist only when ICACHE_PREFETCH_EN is defined.
package icache_pkg;

    localparam int INDEX_BITS = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int LINES      = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_REQ     = 3'd2,
        S_WAIT    = 3'd3,
        S_RESP    = 3'd4
`ifdef ICACHE_PREFETCH_EN
        ,
        S_PF_REQ  = 3'd5,
        S_PF_WAIT = 3'd6
`endif
    } state_t;

    function automatic logic [INDEX_BITS-1:0] get_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[INDEX_BITS+1:2];
    endfunction

    function automatic logic [TAG_BITS-1:0] get_tag(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:INDEX_BITS+2];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_fetch_unit_if.sv
// Fetch-side and memory-controller-side signals of the icache; slave = cache, master = environment.
// Handshakes: fetch_valid_in is a level held with a stable PC until the one-cycle inst_ready_out
// pulse; icache_in is a level held with a stable address until the one-cycle icache_received pulse.
interface icache_fetch_unit_if;
    import icache_pkg::*;

    logic                  fetch_valid_in;
    logic [ADDR_WIDTH-1:0] fetch_pc_in;
    logic                  inst_ready_out;
    logic [31:0]           inst_out;
    logic [ADDR_WIDTH-1:0] inst_pc_out;
    logic                  icache_in;
    logic [ADDR_WIDTH-1:0] icache_address_in;
    logic                  icache_received;
    logic                  icache_task_out;
    logic [31:0]           value_load;

    modport slave (
        input  fetch_valid_in, fetch_pc_in, icache_received, icache_task_out, value_load,
        output inst_ready_out, inst_out, inst_pc_out, icache_in, icache_address_in
    );

    modport master (
        output fetch_valid_in, fetch_pc_in, icache_received, icache_task_out, value_load,
        input  inst_ready_out, inst_out, inst_pc_out, icache_in, icache_address_in
    );

endinterface

// File: rtl/icache_line_store.sv
// Data, tag and valid arrays: one synchronous write port, one combinational read port with hit.
module icache_line_store
    import icache_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] w_index,
    input  logic [TAG_BITS-1:0]   w_tag,
    input  logic [31:0]           w_data,
    input  logic [INDEX_BITS-1:0] r_index,
    input  logic [TAG_BITS-1:0]   r_tag,
    output logic [31:0]           r_data,
    output logic                  hit
);

    logic [31:0]         data_mem [LINES];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    valid;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid <= '0;
        end else if (we) begin
            valid[w_index] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; valid alone decides whether a line is usable.
    always_ff @(posedge clk_in) begin
        if (we) begin
            data_mem[w_index] <= w_data;
            tag_mem[w_index]  <= w_tag;
        end
    end

    assign r_data = data_mem[r_index];
    assign hit    = valid[r_index] && (tag_mem[r_index] == r_tag);

endmodule

// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache: fetch FSM, refill handshake and refill-data forwarding.
// Optional next-line prefetch after a demand miss is enabled by ICACHE_PREFETCH_EN.
module icache_fetch_unit
    import icache_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_in,
    icache_fetch_unit_if.slave bus,
    output logic [2:0]         dbg_state
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [ADDR_WIDTH-1:0] lookup_addr;
    logic [31:0]           inst_q, inst_d;
    logic [31:0]           rd_data;
    logic                  cancel_q, cancel_d;
    logic                  hit;
    logic                  we;
`ifdef ICACHE_PREFETCH_EN
    logic                  miss_q, miss_d;

    // During RESP the read port probes the next line so the prefetch decision costs no cycle.
    assign lookup_addr = (state_q == S_RESP) ? word_align(pc_q + 32'd4) : pc_q;
`else
    assign lookup_addr = pc_q;
`endif

    icache_line_store u_store (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .we      (we && rdy_in && rst_in),
        .w_index (get_index(addr_q)),
        .w_tag   (get_tag(addr_q)),
        .w_data  (bus.value_load),
        .r_index (get_index(lookup_addr)),
        .r_tag   (get_tag(lookup_addr)),
        .r_data  (rd_data),
        .hit     (hit)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cancel_d  = cancel_q;
        we        = 1'b0;
`ifdef ICACHE_PREFETCH_EN
        miss_d    = miss_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.fetch_valid_in && !clear_in) begin
                    pc_d     = bus.fetch_pc_in;
                    cancel_d = 1'b0;
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    inst_d    = rd_data;
                    inst_pc_d = pc_q;
`ifdef ICACHE_PREFETCH_EN
                    miss_d    = 1'b0;
`endif
                    state_d   = clear_in ? S_IDLE : S_RESP;
                end else begin
                    addr_d   = word_align(pc_q);
                    cancel_d = clear_in;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (clear_in) cancel_d = 1'b1;
                if (bus.icache_received) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (clear_in) cancel_d = 1'b1;
                if (bus.icache_task_out) begin
                    we = 1'b1;
                    // A flushed fetch still fills the line but never reaches IF.
                    if (clear_in || cancel_q) begin
                        state_d = S_IDLE;
                    end else begin
                        inst_d    = bus.value_load;
                        inst_pc_d = pc_q;
`ifdef ICACHE_PREFETCH_EN
                        miss_d    = 1'b1;
`endif
                        state_d   = S_RESP;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
`ifdef ICACHE_PREFETCH_EN
                if (miss_q && !hit) begin
                    addr_d  = lookup_addr;
                    state_d = S_PF_REQ;
                end
`endif
            end
`ifdef ICACHE_PREFETCH_EN
            S_PF_REQ: begin
                if (bus.icache_received) state_d = S_PF_WAIT;
            end
            S_PF_WAIT: begin
                if (bus.icache_task_out) begin
                    we      = 1'b1;
                    state_d = S_IDLE;
                    if (bus.fetch_valid_in && !clear_in &&
                        word_align(bus.fetch_pc_in) == addr_q) begin
                        pc_d      = bus.fetch_pc_in;
                        inst_d    = bus.value_load;
                        inst_pc_d = bus.fetch_pc_in;
                        cancel_d  = 1'b0;
                        miss_d    = 1'b0;
                        state_d   = S_RESP;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            addr_q    <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            cancel_q  <= 1'b0;
`ifdef ICACHE_PREFETCH_EN
            miss_q    <= 1'b0;
`endif
        end else if (rdy_in) begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cancel_q  <= cancel_d;
`ifdef ICACHE_PREFETCH_EN
            miss_q    <= miss_d;
`endif
        end
    end

`ifdef ICACHE_PREFETCH_EN
    assign bus.icache_in = (state_q == S_REQ) || (state_q == S_PF_REQ);
`else
    assign bus.icache_in = (state_q == S_REQ);
`endif
    assign bus.icache_address_in = addr_q;
    assign bus.inst_ready_out    = (state_q == S_RESP) && !clear_in;
    assign bus.inst_out          = inst_q;
    assign bus.inst_pc_out       = inst_pc_q;
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Directed bench for icache_fetch_unit with a memory-controller model and expected-word queue.
// Prefetch expectations follow ICACHE_PREFETCH_EN.
module tb_icache_fetch_unit;
    import icache_pkg::*;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rdy_in;
    logic       clear_in;
    logic [2:0] dbg_state;

    icache_fetch_unit_if bus ();

    icache_fetch_unit dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .clear_in  (clear_in),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk_in = ~clk_in;

    int          total = 0;
    int          bad = 0;
    int          bursts = 0;
    int          ready_cnt = 0;
    int          recv_cnt = 0;
    bit          prev_req = 1'b0;
    bit          model_busy = 1'b0;
    logic [31:0] last_req = '0;
    logic [31:0] exp_q[$];

`ifdef ICACHE_PREFETCH_EN
    localparam bit PF_ON = 1'b1;
`else
    localparam bit PF_ON = 1'b0;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0051_3023;
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bus monitor: counts request bursts and response pulses.
    always @(negedge clk_in) begin
        if (bus.icache_in && !prev_req) bursts++;
        prev_req = bus.icache_in;
        if (bus.inst_ready_out) ready_cnt++;
    end

    // Memory-controller model: received one active cycle after the request, data 6 later.
    task automatic step();
        do begin
            @(posedge clk_in);
            #2;
        end while (!rdy_in);
    endtask

    initial begin
        logic [31:0] a;
        bus.icache_received = 1'b0;
        bus.icache_task_out = 1'b0;
        bus.value_load      = '0;
        forever begin
            @(posedge clk_in);
            #2;
            if (bus.icache_in && rdy_in && rst_in) begin
                model_busy = 1'b1;
                a = bus.icache_address_in;
                last_req = a;
                step();
                bus.icache_received = 1'b1;
                recv_cnt++;
                step();
                bus.icache_received = 1'b0;
                repeat (5) step();
                bus.icache_task_out = 1'b1;
                bus.value_load = mem_word(a);
                step();
                bus.icache_task_out = 1'b0;
                model_busy = 1'b0;
            end
        end
    end

    task automatic settle();
        int quiet = 0;
        for (int i = 0; i < 300 && quiet < 2; i++) begin
            @(negedge clk_in);
            if (!model_busy && dbg_state == 3'(S_IDLE) && !bus.icache_in) quiet++;
            else quiet = 0;
        end
        if (quiet < 2) chk("settle_timeout", quiet, 2);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] target);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_in);
            if (dbg_state == target) found = 1'b1;
        end
        if (!found) chk(tag, dbg_state, target);
    endtask

    task automatic apply_reset();
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] pc, input bit miss);
        bit          seen = 1'b0;
        int          lat = 0;
        int          b0;
        int          b_at;
        logic [31:0] got_inst = '0;
        logic [31:0] got_pc = '0;
        logic [31:0] e;
        settle();
        b0 = bursts;
        b_at = bursts;
        exp_q.push_back(mem_word(pc));
        @(posedge clk_in);
        #1;
        bus.fetch_valid_in = 1'b1;
        bus.fetch_pc_in    = pc;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_in);
            if (bus.inst_ready_out) begin
                seen     = 1'b1;
                lat      = i;
                got_inst = bus.inst_out;
                got_pc   = bus.inst_pc_out;
                b_at     = bursts;
            end
        end
        @(posedge clk_in);
        #1 bus.fetch_valid_in = 1'b0;
        e = exp_q.pop_front();
        chk({tag, "_resp"}, 32'(seen), 32'd1);
        chk({tag, "_inst"}, got_inst, e);
        chk({tag, "_pc"}, got_pc, pc);
        chk({tag, "_bursts"}, b_at - b0, miss ? 32'd1 : 32'd0);
        if (!miss) chk({tag, "_lat"}, lat, 32'd2);
    endtask

    initial begin
        int b0;
        int r0;
        int c0;
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        clear_in = 1'b0;
        bus.fetch_valid_in = 1'b0;
        bus.fetch_pc_in    = '0;

        // Reset state
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_ready", bus.inst_ready_out, 0);
        chk("rst_req", bus.icache_in, 0);
        chk("rst_inst", bus.inst_out, 0);
        chk("rst_pc", bus.inst_pc_out, 0);
        chk("rst_addr", bus.icache_address_in, 0);
        chk("rst_state", dbg_state, 3'(S_IDLE));
        @(posedge clk_in);
        #1 rst_in = 1'b1;

        // 1. cold miss, 2. hit
        do_fetch("t1_cold", 32'h0000_1000, 1'b1);
        do_fetch("t2_hit", 32'h0000_1000, 1'b0);

        // 3. conflict on index 0 from a cold cache
        settle();
        apply_reset();
        do_fetch("t3_a", 32'h0000_1000, 1'b1);
        do_fetch("t3_b", 32'h0000_1040, 1'b1);
        do_fetch("t3_c", 32'h0000_1000, 1'b1);

        // 4. flush while waiting for refill data
        settle();
        r0 = ready_cnt;
        b0 = bursts;
        @(posedge clk_in);
        #1;
        bus.fetch_valid_in = 1'b1;
        bus.fetch_pc_in    = 32'h0000_2000;
        wait_state("t4_wait_timeout", 3'(S_WAIT));
        @(posedge clk_in);
        #1;
        clear_in = 1'b1;
        bus.fetch_valid_in = 1'b0;
        @(posedge clk_in);
        #1 clear_in = 1'b0;
        settle();
        chk("t4_no_resp", ready_cnt - r0, 0);
        chk("t4_one_req", bursts - b0, 1);
        do_fetch("t4_hit", 32'h0000_2000, 1'b0);

        // 5. freeze in REQ, then reset in WAIT
        settle();
        b0 = bursts;
        c0 = recv_cnt;
        r0 = ready_cnt;
        @(posedge clk_in);
        #1;
        bus.fetch_valid_in = 1'b1;
        bus.fetch_pc_in    = 32'h0000_5000;
        wait_state("t5_req_timeout", 3'(S_REQ));
        @(posedge clk_in);
        #1 rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("t5_frz_req", bus.icache_in, 1);
            chk("t5_frz_addr", bus.icache_address_in, 32'h0000_5000);
        end
        @(posedge clk_in);
        #1 rdy_in = 1'b1;
        wait_state("t5_wait_timeout", 3'(S_WAIT));
        chk("t5_one_burst", bursts - b0, 1);
        chk("t5_one_recv", recv_cnt - c0, 1);
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        bus.fetch_valid_in = 1'b0;
        @(negedge clk_in);
        chk("t5_rst_req", bus.icache_in, 0);
        chk("t5_rst_state", dbg_state, 3'(S_IDLE));
        chk("t5_rst_addr", bus.icache_address_in, 0);
        for (int i = 0; i < 100 && model_busy; i++) @(negedge clk_in);
        @(negedge clk_in);
        chk("t5_stale_state", dbg_state, 3'(S_IDLE));
        chk("t5_stale_resp", ready_cnt - r0, 0);
        do_fetch("t5_refetch", 32'h0000_5000, 1'b1);

        // 6. next-line prefetch
        do_fetch("t6_miss", 32'h0000_3000, 1'b1);
        b0 = bursts;
        r0 = ready_cnt;
        settle();
        chk("t6_pf_bursts", bursts - b0, PF_ON ? 32'd1 : 32'd0);
        chk("t6_pf_no_resp", ready_cnt - r0, 0);
        if (PF_ON) chk("t6_pf_addr", last_req, 32'h0000_3004);
        do_fetch("t6_next", 32'h0000_3004, !PF_ON);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
